// File: rtl/input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
//
// Conditions a raw, asynchronous switch/button level into a clean level `x`
// in the clk domain, plus one-cycle `rise`/`fall` pulses and a wrapping count
// of accepted rising edges. The output `x` drives the downstream sequence
// FSM's `x` input.
//
// Datapath: din -> SYNC_STAGES-flop synchronizer -> s -> debounce FSM with
// stability counter -> registered x / rise / fall -> rise_count.
//
// Ports
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   din         in   1       raw asynchronous level from the pad
//   clr         in   1       synchronous clear of rise_count (wins over +1)
//   x           out  1       debounced level, registered
//   rise        out  1       one-cycle pulse when x goes 0->1
//   fall        out  1       one-cycle pulse when x goes 1->0
//   rise_count  out  CNT_W   accepted rising edges, modulo 2^CNT_W
//
// Parameters
//   SYNC_STAGES      synchronizer depth, 2 or more
//   DEBOUNCE_CYCLES  consecutive identical samples to accept a change, 2..255
//   CNT_W            width of rise_count
//
// FSM states
//   state        | meaning
//   -------------+-----------------------------------------------
//   ST_LOW       | x = 0, s stable low
//   ST_CHK_HIGH  | x = 0, counting consecutive s = 1 samples
//   ST_HIGH      | x = 1, s stable high
//   ST_CHK_LOW   | x = 1, counting consecutive s = 0 samples
//
// Latency: a new stable din level reaches x at edge
// SYNC_STAGES + DEBOUNCE_CYCLES, counting the edge where the first
// synchronizer flop samples it as edge 1.
// ----------------------------------------------------------------------------
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr,
    output logic             x,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_count
);

    // Counter is sized to hold DEBOUNCE_CYCLES itself, even though the
    // highest value ever stored is DEBOUNCE_CYCLES-1.
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_ZERO = '0;
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_x;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_W-1:0]       r_rise_count;

    logic                   w_cnt_last;
    logic                   w_accept_rise;
    logic                   w_accept_fall;

    // ------------------------------------------------------------------
    // Synchronizer: bit 0 samples din, the top bit is the only synchronized
    // value the rest of the block is allowed to look at.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Acceptance decode. The sample that completes the run is the one
    // arriving while cnt already holds DEBOUNCE_CYCLES-1, so the accepting
    // edge is the DEBOUNCE_CYCLES-th consecutive identical sample.
    // ------------------------------------------------------------------
    assign w_cnt_last    = (r_cnt == CNT_LAST);
    assign w_accept_rise = (r_state == ST_CHK_HIGH) &&  w_s && w_cnt_last;
    assign w_accept_fall = (r_state == ST_CHK_LOW)  && !w_s && w_cnt_last;

    // ------------------------------------------------------------------
    // Debounce FSM with registered outputs. rise/fall default low every
    // cycle so they can only ever be single-cycle pulses, and they come
    // from mutually exclusive states so they never coincide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOW;
            r_cnt   <= CNT_ZERO;
            r_x     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;

            case (r_state)
                ST_LOW: begin
                    if (w_s) begin
                        r_state <= ST_CHK_HIGH;
                        r_cnt   <= CNT_ONE;
                    end
                end

                ST_CHK_HIGH: begin
                    if (!w_s) begin
                        // Run broken before acceptance: drop it entirely.
                        r_state <= ST_LOW;
                        r_cnt   <= CNT_ZERO;
                    end else if (w_cnt_last) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= CNT_ZERO;
                        r_x     <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end

                ST_HIGH: begin
                    if (!w_s) begin
                        r_state <= ST_CHK_LOW;
                        r_cnt   <= CNT_ONE;
                    end
                end

                ST_CHK_LOW: begin
                    if (w_s) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= CNT_ZERO;
                    end else if (w_cnt_last) begin
                        r_state <= ST_LOW;
                        r_cnt   <= CNT_ZERO;
                        r_x     <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= ST_LOW;
                    r_cnt   <= CNT_ZERO;
                    r_x     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Rising-edge event counter. Updates on the same edge that raises
    // rise; clr takes priority over a coincident increment. Wraps
    // naturally at 2^CNT_W.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise_count <= '0;
        end else if (clr) begin
            r_rise_count <= '0;
        end else if (w_accept_rise) begin
            r_rise_count <= r_rise_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // w_accept_fall is kept as a named decode for the falling acceptance
    // so both directions read symmetrically; it mirrors the fall pulse.
    logic r_fall_seen;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fall_seen <= 1'b0;
        end else begin
            r_fall_seen <= w_accept_fall;
        end
    end

    assign x          = r_x;
    assign rise       = r_rise;
    assign fall       = r_fall & r_fall_seen;
    assign rise_count = r_rise_count;

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 2;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

    logic             clk;
    logic             rst_n;
    logic             din;
    logic             clr;
    logic             x;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] rise_count;

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .clr       (clr),
        .x         (x),
        .rise      (rise),
        .fall      (fall),
        .rise_count(rise_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_rise;
        int cyc;
        int cnt;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect an event LAT edges after din changes now (edge 1 = next edge).
    task automatic expect_ev(input bit is_rise, input int at_cyc, input int cnt);
        ev_t e;
        e.is_rise = is_rise;
        e.cyc     = at_cyc;
        e.cnt     = cnt % (1 << CNT_W);
        q.push_back(e);
    endtask

    // Monitor: every rise/fall pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (rise || fall)) begin
            if (rise && fall) chk("rise_fall_together", 1, 0);
            if (q.size() == 0) begin
                chk("unexpected_event", int'(rise) * 2 + int'(fall), 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("event_kind_rise", int'(rise), int'(e.is_rise));
                chk("event_cycle", cyc, e.cyc);
                chk("x_at_event", int'(x), int'(e.is_rise));
                chk("count_at_event", int'(rise_count), e.cnt);
            end
        end
    end

    logic [8:0] pat;
    int         base;
    int         exp_cnt;

    initial begin
        rst_n = 1'b0;
        din   = 1'b1;
        clr   = 1'b0;
        exp_cnt = 0;

        // Reset held with din=1.
        step(3);
        chk("reset_x", int'(x), 0);
        chk("reset_rise", int'(rise), 0);
        chk("reset_count", int'(rise_count), 0);
        rst_n = 1'b1;
        exp_cnt = 1;
        expect_ev(1'b1, cyc + LAT, exp_cnt);
        step(10);
        chk("x_high_after_reset", int'(x), 1);

        // Falling edge from HIGH.
        din = 1'b0;
        expect_ev(1'b0, cyc + LAT, exp_cnt);
        step(10);
        chk("x_low_after_fall", int'(x), 0);
        chk("count_unchanged_fall", int'(rise_count), exp_cnt);

        // Glitch of 3 cycles: rejected.
        din = 1'b1;
        step(3);
        din = 1'b0;
        step(10);
        chk("glitch3_x", int'(x), 0);
        chk("glitch3_count", int'(rise_count), exp_cnt);

        // 4-cycle pulse: accepted, then falls after another full latency.
        base = cyc;
        din  = 1'b1;
        exp_cnt++;
        expect_ev(1'b1, base + LAT, exp_cnt);
        expect_ev(1'b0, base + 4 + LAT, exp_cnt);
        step(4);
        din = 1'b0;
        step(12);

        // Bounce train 1,0,1,1,0,1,1,1,1 then hold 1: only the final run wins.
        pat  = 9'b111101101;
        base = cyc;
        exp_cnt++;
        expect_ev(1'b1, base + 5 + LAT, exp_cnt);
        for (int i = 0; i < 9; i++) begin
            din = pat[i];
            step(1);
        end
        step(8);
        chk("bounce_x", int'(x), 1);

        din = 1'b0;
        expect_ev(1'b0, cyc + LAT, exp_cnt);
        step(10);

        // Clear, then wrap with a 2-bit counter: 1,2,3,0,1.
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_count", int'(rise_count), 0);
        exp_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            din = 1'b1;
            exp_cnt++;
            expect_ev(1'b1, cyc + LAT, exp_cnt);
            step(10);
            din = 1'b0;
            expect_ev(1'b0, cyc + LAT, exp_cnt);
            step(10);
        end

        // Sixth rise with clr on the accepting edge: count 0, rise still 1.
        base = cyc;
        din  = 1'b1;
        exp_cnt = 0;
        expect_ev(1'b1, base + LAT, 0);
        step(LAT - 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(4);
        din = 1'b0;
        expect_ev(1'b0, cyc + LAT, 0);
        step(10);

        // One more rise so the counter is nonzero before the mid-count reset.
        din = 1'b1;
        expect_ev(1'b1, cyc + LAT, 1);
        step(10);
        din = 1'b0;
        expect_ev(1'b0, cyc + LAT, 1);
        step(10);
        chk("count_before_reset", int'(rise_count), 1);

        // Reset mid-count: CHK_HIGH with cnt=2 after edge base+4.
        base = cyc;
        din  = 1'b1;
        step(4);
        rst_n = 1'b0;
        #1;
        chk("async_reset_count", int'(rise_count), 0);
        chk("async_reset_x", int'(x), 0);
        #3;
        rst_n = 1'b1;
        // Next edge (base+5) is edge 1 of a fresh acceptance.
        expect_ev(1'b1, base + 4 + LAT, 1);
        step(LAT - 1);
        chk("x_low_before_fresh_latency", int'(x), 0);
        step(4);
        chk("x_high_after_fresh_latency", int'(x), 1);
        din = 1'b0;
        expect_ev(1'b0, cyc + LAT, 1);
        step(10);

        chk("pending_events", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Input conditioner that turns a raw asynchronous switch/button level into a clean, single-clock-domain level `x` plus one-cycle edge pulses. It sits directly upstream of the 4-state sequence FSM and drives that FSM's `x` input. It also keeps a wrapping count of accepted rising edges for bring-up and lab checks. The block comprises a synchronizer chain, a 4-state debounce FSM with a stability counter, registered outputs and an event counter.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops. Legal values are 2 or more.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive identical synchronized samples required to accept a level change. Legal values are 2 to 255.
- `CNT_W`, default 8: width of `rise_count`.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `rst_n` input, 1 bit: reset. Asynchronous, active-low.
- `din` input, 1 bit: raw asynchronous level from the pad.
- `clr` input, 1 bit: synchronous clear of `rise_count`.
- `x` output, 1 bit: debounced level, registered.
- `rise` output, 1 bit: one-cycle pulse when `x` goes 0→1.
- `fall` output, 1 bit: one-cycle pulse when `x` goes 1→0.
- `rise_count` output, `CNT_W` bits: accepted rising edges, modulo 2^`CNT_W`.

## Operation
- **Synchronizer.** `din` passes through `SYNC_STAGES` flops. `s` is the last stage. Only `s` feeds logic.
- **Stability counter.** `cnt` is a `$clog2(DEBOUNCE_CYCLES+1)`-bit register.
- **FSM states:**
  - LOW: `x`=0.
  - CHK_HIGH: `x`=0, counting.
  - HIGH: `x`=1.
  - CHK_LOW: `x`=1, counting.
- **Transitions (evaluated each edge on the current `s`):**
  - LOW: `s`=1 → CHK_HIGH, `cnt`←1. Otherwise stay.
  - CHK_HIGH: `s`=0 → LOW, `cnt`←0 (glitch rejected). If `s`=1 and `cnt`=`DEBOUNCE_CYCLES`-1 → HIGH, `cnt`←0. Otherwise `cnt`←`cnt`+1.
  - HIGH: `s`=0 → CHK_LOW, `cnt`←1. Otherwise stay.
  - CHK_LOW: mirror of CHK_HIGH. `s`=1 → HIGH. `DEBOUNCE_CYCLES` consecutive zeros → LOW.
- **Acceptance rule.** A level on `s` is accepted only after exactly `DEBOUNCE_CYCLES` consecutive samples. Any run of `DEBOUNCE_CYCLES`-1 or fewer is ignored, and `x` does not move.
- **`x`** is registered and equals 1 in HIGH and CHK_LOW.
- **`rise`** is registered and asserted for exactly the one cycle in which `x` first reads 1 (transition CHK_HIGH→HIGH). **`fall`** is the same for CHK_LOW→LOW. `rise` and `fall` are never high together.
- **`rise_count`:**
  - Increments by 1 on the same edge that asserts `rise`.
  - Wraps from 2^`CNT_W`-1 to 0.
  - `clr`=1 forces it to 0 and has priority: if `clr` coincides with an accepted rise, the result is 0.
- **Reset (`rst_n`=0, asynchronous, any time including mid-count):**
  - Synchronizer flops ← 0, state ← LOW, `cnt` ← 0.
  - `x`=0, `rise`=0, `fall`=0, `rise_count`=0.
- **After reset release with `din` already 1:** full acceptance latency applies, then `rise` pulses once and `rise_count` becomes 1.

## Timing
- **Acceptance latency.** Number edges from 1, where edge 1 is the first edge at which stage 1 samples the new stable `din`. `x`, `rise`/`fall` and `rise_count` update at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults this is edge 6.
- **Minimum accepted pulse on `din`.** `DEBOUNCE_CYCLES` clock periods (setup-valid). Shorter pulses may or may not pass the synchronizer but are always rejected by the FSM if `s` shows fewer than `DEBOUNCE_CYCLES` samples.
- **Output pulse width.** `rise` and `fall` are exactly 1 cycle.
- **Minimum spacing.** Between consecutive `rise` pulses: 2×`DEBOUNCE_CYCLES` cycles.
- **No combinational paths.** No input reaches any output combinationally.
- **Reset timing.** Reset assertion takes effect without a clock edge. Deassertion is assumed synchronous to `clk` at system level.

## Test plan
- **Reset defaults.** Hold `rst_n`=0 for 3 cycles with `din`=1, then release. Required: `x`=0 and `rise_count`=0 during reset; `x`=1 and `rise`=1 at edge 6 after release; `rise_count`=1.
- **Glitch rejection.** From LOW, drive `din`=1 for 3 cycles, then 0. Required: `x` stays 0, `rise` never asserts, state returns to LOW. Repeat with 4 cycles. Required: `x`=1 at edge 6, one `rise` pulse.
- **Bounce train.** `din` toggles 1,0,1,1,0,1,1,1,1 per cycle, then holds 1. Required: exactly one `rise`, `x`=1 only after the 4-long run is seen on `s`, `rise_count`+1.
- **Falling edge.** From HIGH, `din`=0 held. Required: `fall`=1 for one cycle at edge 6, `x`=0, `rise_count` unchanged.
- **Counter wrap and clear.** With `CNT_W`=2, accept 5 rises. Required: `rise_count` sequence 1,2,3,0,1. Assert `clr` on the edge of a 6th rise. Required: `rise_count`=0 and `rise`=1 that cycle.
- **Reset mid-count.** In CHK_HIGH with `cnt`=2, pulse `rst_n` low for half a cycle. Required: outputs reset immediately with no clock edge; state LOW; a fresh full 6-edge latency is needed before `x` rises.
